// File: rtl/vc_pop_scheduler_pkg.sv
// Shared types and defaults for the two-VC pop scheduler.
package vc_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int DATA_SIZE_DEF = 10;
  localparam int PTR_SIZE_DEF  = 4;
  localparam int DEST_BIT_DEF  = 8;
  localparam int WEIGHT_DEF    = 3;
  // pop -> read-data sample -> push
  localparam int PIPE_STAGES   = 2;

endpackage

// File: rtl/vc_pop_scheduler_if.sv
// VC-side and destination-side datapath of the pop scheduler; master = scheduler.
interface vc_pop_scheduler_if #(
  parameter int DATA_SIZE = vc_pkg::DATA_SIZE_DEF
);
  logic                 fifo_empty_vc0;
  logic                 fifo_empty_vc1;
  logic                 fifo_error_vc0;
  logic                 fifo_error_vc1;
  logic [DATA_SIZE-1:0] data_mux_0;
  logic [DATA_SIZE-1:0] data_mux_1;
  logic                 pause_d0;
  logic                 pause_d1;
  logic                 pop_vc0;
  logic                 pop_vc1;
  logic                 push_d0;
  logic                 push_d1;
  logic [DATA_SIZE-1:0] data_out;

  modport master (
    input  fifo_empty_vc0, fifo_empty_vc1, fifo_error_vc0, fifo_error_vc1,
    input  data_mux_0, data_mux_1, pause_d0, pause_d1,
    output pop_vc0, pop_vc1, push_d0, push_d1, data_out
  );

  modport slave (
    output fifo_empty_vc0, fifo_empty_vc1, fifo_error_vc0, fifo_error_vc1,
    output data_mux_0, data_mux_1, pause_d0, pause_d1,
    input  pop_vc0, pop_vc1, push_d0, push_d1, data_out
  );
endinterface

// File: rtl/vc_pop_scheduler_arbiter.sv
// VC grant logic: strict vc0 priority, or weighted round robin when VC_WRR_EN is defined.
module vc_pop_arbiter #(
  parameter int WEIGHT = vc_pkg::WEIGHT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic eligible,
  input  logic empty_vc0,
  input  logic empty_vc1,
  output logic grant_vc0,
  output logic grant_vc1
);

`ifdef VC_WRR_EN
  localparam int CW = (WEIGHT < 1) ? 1 : $clog2(WEIGHT + 1);

  logic [CW-1:0] run_cnt;
  logic          vc1_turn;

  // vc1 is served once vc0 has used up its run, or whenever vc0 has nothing
  assign vc1_turn  = !empty_vc1 && (empty_vc0 || (run_cnt >= CW'(WEIGHT)));
  assign grant_vc1 = eligible && vc1_turn;
  assign grant_vc0 = eligible && !vc1_turn && !empty_vc0;

  always_ff @(posedge clk) begin
    if (reset || !active || empty_vc1 || grant_vc1)
      run_cnt <= '0;
    else if (grant_vc0 && (run_cnt != CW'(WEIGHT)))
      run_cnt <= run_cnt + 1'b1;
  end
`else
  localparam int unused_weight = WEIGHT;
  logic unused_wrr;

  assign unused_wrr = ^{clk, reset, active};
  assign grant_vc0  = eligible && !empty_vc0;
  assign grant_vc1  = eligible && empty_vc0 && !empty_vc1;
`endif

endmodule

// File: rtl/vc_pop_scheduler.sv
// Two-VC pop scheduler: threshold config, pop sequencing and D0/D1 routing.
// Optional weighted round robin arbitration enabled by defining VC_WRR_EN.
module vc_pop_scheduler
  import vc_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int PTR_SIZE  = PTR_SIZE_DEF,
  parameter int DEST_BIT  = DEST_BIT_DEF,
  parameter int WEIGHT    = WEIGHT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [PTR_SIZE-1:0] umbral_af,
  input  logic [PTR_SIZE-1:0] umbral_ae,
  output logic [PTR_SIZE-1:0] afVC_o,
  output logic [PTR_SIZE-1:0] aeVC_o,
  output logic [2:0]          state_o,
  output logic                idle_o,
  vc_pop_scheduler_if.master  bus
);

  state_t               state, state_nx;
  logic                 err, eligible, grant_vc0, grant_vc1, issue;
  logic [PIPE_STAGES:1] vld_pipe;
  logic                 sel_vc1, push_d0_q, push_d1_q;
  logic [DATA_SIZE-1:0] rd_word, data_q;

  assign err = bus.fifo_error_vc0 | bus.fifo_error_vc1;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RESET:  state_nx = ST_INIT;
      ST_INIT:   if (!init) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (init) state_nx = ST_INIT;
        else if (!bus.fifo_empty_vc0 || !bus.fifo_empty_vc1) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init) state_nx = ST_INIT;
        else if (bus.fifo_empty_vc0 && bus.fifo_empty_vc1 && !(|vld_pipe))
          state_nx = ST_IDLE;
      end
      ST_ERROR:  state_nx = ST_ERROR;
      default:   state_nx = ST_RESET;
    endcase
    if (err && (state != ST_RESET)) state_nx = ST_ERROR;
  end

  // Pops are decided in-cycle so the empty flags already reflect the previous
  // pop; this allows back-to-back pops without underflowing a one-word VC.
  assign eligible = (state == ST_ACTIVE) && !reset && !init && !err &&
                    !bus.pause_d0 && !bus.pause_d1;

  vc_pop_arbiter #(.WEIGHT(WEIGHT)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .active    (state == ST_ACTIVE),
    .eligible  (eligible),
    .empty_vc0 (bus.fifo_empty_vc0),
    .empty_vc1 (bus.fifo_empty_vc1),
    .grant_vc0 (grant_vc0),
    .grant_vc1 (grant_vc1)
  );

  assign issue       = grant_vc0 | grant_vc1;
  assign bus.pop_vc0 = grant_vc0;
  assign bus.pop_vc1 = grant_vc1;

  always_ff @(posedge clk) begin
    if (reset) begin
      afVC_o <= '0;
      aeVC_o <= '0;
    end else if (state == ST_INIT) begin
      afVC_o <= umbral_af;
      aeVC_o <= umbral_ae;
    end
  end

  assign rd_word = sel_vc1 ? bus.data_mux_1 : bus.data_mux_0;

  // In-flight words always complete, whatever the state or pause inputs do.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      sel_vc1   <= 1'b0;
      data_q    <= '0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[PIPE_STAGES-1:1], issue};
      sel_vc1   <= grant_vc1;
      push_d0_q <= vld_pipe[1] & ~rd_word[DEST_BIT];
      push_d1_q <= vld_pipe[1] &  rd_word[DEST_BIT];
      if (vld_pipe[1]) data_q <= rd_word;
    end
  end

  assign bus.push_d0  = push_d0_q;
  assign bus.push_d1  = push_d1_q;
  assign bus.data_out = data_q;
  assign state_o      = state;
  assign idle_o       = (state == ST_IDLE);

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Bench for vc_pop_scheduler: config vector table plus scoreboarded pop/push sequences.
// Expected arbitration order follows VC_WRR_EN when it is defined.
module tb_vc_pop_scheduler;
  import vc_pkg::*;

  localparam int DW = 10;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset, init;
  logic [PW-1:0] umbral_af, umbral_ae, afVC_o, aeVC_o;
  logic [2:0]    state_o;
  logic          idle_o;

  vc_pop_scheduler_if #(.DATA_SIZE(DW)) bus ();

  vc_pop_scheduler #(.DATA_SIZE(DW), .PTR_SIZE(PW), .DEST_BIT(8), .WEIGHT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .umbral_af (umbral_af),
    .umbral_ae (umbral_ae),
    .afVC_o    (afVC_o),
    .aeVC_o    (aeVC_o),
    .state_o   (state_o),
    .idle_o    (idle_o),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // VC FIFO models: read data appears the cycle after a pop
  logic          fill0 = 1'b0, fill1 = 1'b0;
  logic [DW-1:0] fill_w0 = '0, fill_w1 = '0;
  logic [DW-1:0] q0[$], q1[$];
  logic          uflow = 1'b0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill0) q0.push_back(fill_w0);
    if (fill1) q1.push_back(fill_w1);
    if (bus.pop_vc0) begin
      if (q0.size() == 0) uflow <= 1'b1;
      else bus.data_mux_0 <= q0.pop_front();
    end
    if (bus.pop_vc1) begin
      if (q1.size() == 0) uflow <= 1'b1;
      else bus.data_mux_1 <= q1.pop_front();
    end
    bus.fifo_empty_vc0 <= (q0.size() == 0);
    bus.fifo_empty_vc1 <= (q1.size() == 0);
  end

  // Event logs sampled mid-cycle
  typedef struct { int cyc; logic vc1; } pop_ev_t;
  typedef struct { int cyc; logic d0; logic d1; logic [DW-1:0] data; } push_ev_t;
  pop_ev_t  pop_log[$];
  push_ev_t push_log[$];
  pop_ev_t  pe;
  push_ev_t se;
  int       both_cnt = 0;

  always @(negedge clk) begin
    if (bus.pop_vc0 | bus.pop_vc1) begin
      pe.cyc = cyc; pe.vc1 = bus.pop_vc1;
      pop_log.push_back(pe);
    end
    if (bus.push_d0 | bus.push_d1) begin
      se.cyc = cyc; se.d0 = bus.push_d0; se.d1 = bus.push_d1; se.data = bus.data_out;
      push_log.push_back(se);
    end
    if ((bus.pop_vc0 & bus.pop_vc1) | (bus.push_d0 & bus.push_d1)) both_cnt <= both_cnt + 1;
  end

  typedef struct { logic [DW-1:0] word; logic vc1; } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic rst; logic ini; logic [3:0] af; logic [3:0] ae;
    logic [2:0] st; logic [3:0] eaf; logic [3:0] eae; logic idle;
  } vec_t;
  vec_t vecs[8];

  int checks = 0, failures = 0;

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add_exp(logic vc1, logic [DW-1:0] w);
    exp_t e;
    e.word = w; e.vc1 = vc1;
    exp_q.push_back(e);
  endtask

  task automatic fill2(logic e0, logic [DW-1:0] w0, logic e1, logic [DW-1:0] w1);
    fill0 = e0; fill_w0 = w0; fill1 = e1; fill_w1 = w1;
    step();
    fill0 = 1'b0; fill1 = 1'b0;
  endtask

  task automatic wait_state(logic [2:0] st, string nm);
    int t = 0;
    while (state_o !== st && t < 50) begin step(); t++; end
    chk(nm, state_o, st);
  endtask

  task automatic check_flow(int pop_base, int push_base, string nm);
    int   n = exp_q.size();
    int   t = 0;
    exp_t e;
    while (push_log.size() < push_base + n && t < 200) begin step(); t++; end
    chk($sformatf("%s.pushes", nm), push_log.size() - push_base, n);
    chk($sformatf("%s.pops", nm), pop_log.size() - pop_base, n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (pop_base + i < pop_log.size() && push_base + i < push_log.size()) begin
        chk($sformatf("%s[%0d].vc", nm, i), pop_log[pop_base+i].vc1, e.vc1);
        chk($sformatf("%s[%0d].data", nm, i), push_log[push_base+i].data, e.word);
        chk($sformatf("%s[%0d].d1", nm, i), push_log[push_base+i].d1, e.word[8]);
        chk($sformatf("%s[%0d].d0", nm, i), push_log[push_base+i].d0, !e.word[8]);
        chk($sformatf("%s[%0d].lat", nm, i),
            push_log[push_base+i].cyc - pop_log[pop_base+i].cyc, 2);
      end
    end
  endtask

  logic [DW-1:0] w_vc0[5], w_vc1[3];
  bit            ord[8];
  int            pb, sb, n0, n, i0, i1;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd6, 4'd2, 3'd0, 4'd0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'd6, 4'd2, 3'd0, 4'd0, 4'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'd6, 4'd2, 3'd1, 4'd0, 4'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'd6, 4'd2, 3'd2, 4'd6, 4'd2, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'd6, 4'd2, 3'd2, 4'd6, 4'd2, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 4'd9, 4'd3, 3'd1, 4'd6, 4'd2, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'd9, 4'd3, 3'd2, 4'd9, 4'd3, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'd1, 4'd1, 3'd2, 4'd9, 4'd3, 1'b1};
    w_vc0 = '{10'h011, 10'h122, 10'h033, 10'h177, 10'h088};
    w_vc1 = '{10'h144, 10'h055, 10'h166};

    bus.pause_d0 = 1'b0; bus.pause_d1 = 1'b0;
    bus.fifo_error_vc0 = 1'b0; bus.fifo_error_vc1 = 1'b0;

    // Reset and threshold configuration
    foreach (vecs[i]) begin
      reset = vecs[i].rst; init = vecs[i].ini;
      umbral_af = vecs[i].af; umbral_ae = vecs[i].ae;
      step();
      chk($sformatf("vec%0d.state", i), state_o, vecs[i].st);
      chk($sformatf("vec%0d.af", i), afVC_o, vecs[i].eaf);
      chk($sformatf("vec%0d.ae", i), aeVC_o, vecs[i].eae);
      chk($sformatf("vec%0d.idle", i), idle_o, vecs[i].idle);
      chk($sformatf("vec%0d.pops", i), pop_log.size(), 0);
    end

    // Single word to D1
    pb = pop_log.size(); sb = push_log.size();
    add_exp(1'b0, 10'h155);
    fill2(1'b1, 10'h155, 1'b0, '0);
    check_flow(pb, sb, "single");
    wait_state(3'd2, "single.idle_state");
    chk("single.idle_o", idle_o, 1'b1);

    // Arbitration order with both VCs loaded under pause
`ifdef VC_WRR_EN
    n0 = 5; ord = '{0, 0, 0, 1, 0, 0, 1, 1};
`else
    n0 = 3; ord = '{0, 0, 0, 1, 1, 1, 0, 0};
`endif
    n = n0 + 3; i0 = 0; i1 = 0;
    bus.pause_d0 = 1'b1;
    pb = pop_log.size(); sb = push_log.size();
    for (int i = 0; i < n; i++) begin
      if (ord[i]) begin add_exp(1'b1, w_vc1[i1]); i1++; end
      else        begin add_exp(1'b0, w_vc0[i0]); i0++; end
    end
    for (int i = 0; i < n0; i++) fill2(1'b1, w_vc0[i], i < 3, w_vc1[i % 3]);
    step(2);
    chk("prio.held_by_pause", pop_log.size() - pb, 0);
    bus.pause_d0 = 1'b0;
    check_flow(pb, sb, "prio");
    if (pop_log.size() >= pb + n)
      chk("prio.back_to_back", pop_log[pb+n-1].cyc - pop_log[pb].cyc, n - 1);
    wait_state(3'd2, "prio.idle_state");

    // Pause raised the cycle after a pop: in-flight word still pushes
    bus.pause_d0 = 1'b1;
    add_exp(1'b0, 10'h0F3); add_exp(1'b0, 10'h1C4);
    fill2(1'b1, 10'h0F3, 1'b0, '0);
    fill2(1'b1, 10'h1C4, 1'b0, '0);
    step(2);
    pb = pop_log.size(); sb = push_log.size();
    bus.pause_d0 = 1'b0;
    step();
    bus.pause_d0 = 1'b1;
    step(4);
    chk("bp.pops_held", pop_log.size() - pb, 1);
    chk("bp.inflight_push", push_log.size() - sb, 1);
    bus.pause_d0 = 1'b0;
    check_flow(pb, sb, "bp");
    wait_state(3'd2, "bp.idle_state");

    // Error is sticky over init, cleared only by reset
    bus.pause_d1 = 1'b1;
    pb = pop_log.size(); sb = push_log.size();
    fill2(1'b1, 10'h1AA, 1'b0, '0);
    fill2(1'b1, 10'h055, 1'b0, '0);
    step(2);
    chk("err.active", state_o, 3'd3);
    chk("err.pause_d1_blocks", pop_log.size() - pb, 0);
    bus.fifo_error_vc1 = 1'b1;
    step();
    bus.fifo_error_vc1 = 1'b0;
    chk("err.state", state_o, 3'd4);
    bus.pause_d1 = 1'b0;
    init = 1'b1; umbral_af = 4'd6; umbral_ae = 4'd2;
    step(2);
    init = 1'b0;
    step(3);
    chk("err.sticky", state_o, 3'd4);
    chk("err.no_pops", pop_log.size() - pb, 0);
    reset = 1'b1;
    step(2);
    chk("err.reset_state", state_o, 3'd0);
    chk("err.reset_af", afVC_o, 4'd0);
    reset = 1'b0; init = 1'b1;
    step();
    init = 1'b0;
    step();
    chk("err.reinit_state", state_o, 3'd2);
    chk("err.reinit_af", afVC_o, 4'd6);
    add_exp(1'b0, 10'h1AA); add_exp(1'b0, 10'h055);
    check_flow(pb, sb, "err.drain");
    wait_state(3'd2, "err.idle_state");

    // Reset the cycle after a pop discards the word
    bus.pause_d0 = 1'b1;
    fill2(1'b1, 10'h1F0, 1'b0, '0);
    step(2);
    pb = pop_log.size(); sb = push_log.size();
    bus.pause_d0 = 1'b0;
    step();
    chk("rst.popped", pop_log.size() - pb, 1);
    reset = 1'b1;
    step();
    chk("rst.state", state_o, 3'd0);
    chk("rst.push_d0", bus.push_d0, 1'b0);
    chk("rst.push_d1", bus.push_d1, 1'b0);
    chk("rst.data_out", bus.data_out, 0);
    chk("rst.idle", idle_o, 1'b0);
    chk("rst.pop", {bus.pop_vc0, bus.pop_vc1}, 0);
    step(3);
    chk("rst.no_push", push_log.size() - sb, 0);
    reset = 1'b0; init = 1'b1;
    step();
    init = 1'b0;
    step(3);
    chk("rst.idle_state", state_o, 3'd2);
    chk("rst.no_late_push", push_log.size() - sb, 0);

    chk("underflow", uflow, 1'b0);
    chk("exclusive_strobes", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vc_pop_scheduler.md
Name: vc_pop_scheduler

Overview:
- Controller for the two-VC classification stage: configures the VC FIFO almost-full/almost-empty thresholds and sequences pops from fifo_vc0/fifo_vc1.
- Popped words are routed to one of two destination FIFOs (D0/D1) by a destination bit.
- Sits between the VC FIFO pair and the destination FIFO pair.
- Owns the main FSM: RESET, INIT, IDLE, ACTIVE, ERROR.

Parameters:
- DATA_SIZE, 10, width of data words.
- PTR_SIZE, 4, width of threshold fields (afVC/aeVC).
- DEST_BIT, 8, bit of the popped word selecting destination (0 selects D0, 1 selects D1).
- WEIGHT, 3, consecutive vc0 grants allowed before vc1 is served (used only with VC_WRR_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  request to (re)load thresholds.
- umbral_af  in  PTR_SIZE  almost-full threshold to load.
- umbral_ae  in  PTR_SIZE  almost-empty threshold to load.
- fifo_empty_vc0  in  1  vc0 empty.
- fifo_empty_vc1  in  1  vc1 empty.
- fifo_error_vc0  in  1  vc0 overflow/underflow.
- fifo_error_vc1  in  1  vc1 overflow/underflow.
- data_mux_0  in  DATA_SIZE  vc0 read data; valid the cycle after pop_vc0.
- data_mux_1  in  DATA_SIZE  vc1 read data; valid the cycle after pop_vc1.
- pause_d0  in  1  D0 almost full.
- pause_d1  in  1  D1 almost full.
- afVC_o  out  PTR_SIZE  registered almost-full threshold.
- aeVC_o  out  PTR_SIZE  registered almost-empty threshold.
- pop_vc0  out  1  pop strobe to vc0.
- pop_vc1  out  1  pop strobe to vc1.
- push_d0  out  1  push strobe to D0.
- push_d1  out  1  push strobe to D1.
- data_out  out  DATA_SIZE  word to destination FIFOs.
- state_o  out  3  current state (RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4).
- idle_o  out  1  high in IDLE.

Behaviour:
- Reset (reset=1 at edge):
  - state=RESET; all strobes 0; data_out=0; idle_o=0.
  - afVC_o and aeVC_o reset to 0.
  - Pipeline valid flags cleared.
  - Reset mid-transfer discards in-flight words.
- RESET -> INIT on the first cycle with reset=0.
- INIT:
  - Each cycle, afVC_o<=umbral_af and aeVC_o<=umbral_ae.
  - No pops issued.
  - Moves to IDLE when init=0.
- IDLE:
  - idle_o=1.
  - init=1 -> INIT.
  - Else either VC non-empty -> ACTIVE.
- ACTIVE:
  - Pops are issued.
  - Moves to IDLE when both VCs are empty and the pipeline is drained.
  - init=1 -> INIT: pop issue stops immediately; in-flight words still complete.
- ERROR:
  - Entered from any non-RESET state when fifo_error_vc0 or fifo_error_vc1 is 1.
  - Sticky until reset; no pops issued.
  - Error has priority over init.
- Pop eligibility (cycle N): state ACTIVE, pause_d0=0, pause_d1=0, selected VC non-empty. Both pauses block because the destination is unknown before the read.
- Arbitration: strict priority, vc0 before vc1. pop_vc0 and pop_vc1 are never high together.
- Pipeline:
  - Pop at N; read data sampled at N+1 from the VC recorded in a select register.
  - At N+2: data_out holds the word, and push_d0 or push_d1 (per word[DEST_BIT]) is high for exactly 1 cycle.
  - Pop-to-push latency is 2 cycles. Back-to-back pops give one push per cycle.
- Pause asserted while words are in flight: pushes of those words still complete. Destination FIFOs size afVC headroom ≥2 for this.
- Strobe outputs are registered; data_out holds its value when no push is issued.

Optional Feature:
- VC_WRR_EN defined:
  - Weighted round robin: vc0 is granted at most WEIGHT consecutive pops while vc1 is non-empty, then vc1 gets 1 pop.
  - Grant counter resets on a vc1 grant, on vc1 empty, or on leaving ACTIVE.
- VC_WRR_EN undefined: strict vc0 priority; no counter logic.

Decomposition:
- Shared package (vc_pkg):
  - state encodings: ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR.
  - default DATA_SIZE, PTR_SIZE, DEST_BIT.
- One sub-module, vc_pop_arbiter: combinational-plus-counter grant logic (priority/WRR). Produces grant_vc0 and grant_vc1 from the empty flags and the eligibility bit.

Test Plan:
- Reset and config: reset 2 cycles, then init=1 with umbral_af=4'd6, umbral_ae=4'd2 for 1 cycle, then init=0 -> state 0->1->2; afVC_o=6, aeVC_o=2; no pops.
- Single word: vc0 holds 10'h155 (bit8=1), vc1 empty -> pop_vc0 at N; push_d1=1 with data_out=10'h155 at N+2; state returns to IDLE.
- Priority: both VCs hold 3 words -> pops ordered vc0×3 then vc1×3 (without VC_WRR_EN). With VC_WRR_EN and WEIGHT=3, vc0 holds 5 words -> order vc0,vc0,vc0,vc1,vc0,vc0,vc1,vc1.
- Backpressure: pause_d0=1 raised one cycle after a pop -> that word is still pushed at N+2; no further pops until pause_d0=0.
- Error: fifo_error_vc1=1 for 1 cycle during ACTIVE -> state=4 from the next cycle; pops stay 0 through init pulses; reset returns to RESET.
- Reset mid-flight: reset asserted the cycle after a pop -> no push is issued; all outputs are 0 on the next cycle.
